// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: shared ALUOp codes, slice width, sequencer states and op legality check
package alu_ctrl_pkg;
  localparam int SLICE_W = 6;
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_NOR = 4'b1100;
  typedef enum logic [1:0] {IDLE, PASS, DONE} state_t;
  function automatic logic is_legal_op(input logic [3:0] op);
    return op inside {OP_AND, OP_OR, OP_ADD, OP_SUB, OP_NOR};
  endfunction
endpackage

// File: rtl/ALU_6_bit.sv
// ALU_6_bit: 6-bit AND/OR/ADD/SUB/NOR slice with carry in/out
module ALU_6_bit
  import alu_ctrl_pkg::*;
(
  input  logic [3:0] ALUOp,
  input  logic [5:0] a,
  input  logic [5:0] b,
  input  logic       CarryIn,
  output logic [5:0] Result,
  output logic       CarryOut
);
  logic [6:0] sum;
  logic       arith;
  always_comb begin
    arith    = (ALUOp == OP_ADD) || (ALUOp == OP_SUB);
    sum      = {1'b0, a} + {1'b0, (ALUOp == OP_SUB) ? ~b : b} + {6'b0, CarryIn};
    Result   = (ALUOp == OP_AND) ? (a & b) :
               (ALUOp == OP_OR)  ? (a | b) :
               (ALUOp == OP_NOR) ? ~(a | b) :
               arith             ? sum[5:0] : 6'b0;
    CarryOut = arith & sum[6];
  end
endmodule

// File: rtl/alu_multipass_seq.sv
// alu_multipass_seq: WIDTH-bit ALU op built from PASSES sequential passes through one ALU_6_bit
module alu_multipass_seq
  import alu_ctrl_pkg::*;
#(
  parameter int PASSES = 2,
  localparam int WIDTH = SLICE_W * PASSES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carry,
  output logic             out_zero,
  output logic             out_ovf,
  output logic             out_err
);
  state_t             state_q;
  logic [3:0]         idx_q, op_q;
  logic [WIDTH-1:0]   a_q, b_q, res_q, res_d;
  logic               carry_q, err_q;
  logic               out_valid_q, out_carry_q, out_zero_q, out_ovf_q, out_err_q;
  logic [WIDTH-1:0]   out_result_q;
  logic [3:0]         alu_op;
  logic [5:0]         alu_a, alu_b, alu_res;
  logic               alu_cin, alu_cout, drive, last, addsub, ovf_d;
  ALU_6_bit u_alu (
    .ALUOp   (alu_op),
    .a       (alu_a),
    .b       (alu_b),
    .CarryIn (alu_cin),
    .Result  (alu_res),
    .CarryOut(alu_cout)
  );
  // ALU inputs stay at zero outside a legal pass so it sees no spurious activity
  always_comb begin
    drive   = (state_q == PASS) && !err_q;
    last    = idx_q == 4'(PASSES - 1);
    addsub  = (op_q == OP_ADD) || (op_q == OP_SUB);
    alu_op  = drive ? op_q : 4'b0;
    alu_a   = drive ? a_q[SLICE_W*idx_q +: SLICE_W] : 6'b0;
    alu_b   = drive ? b_q[SLICE_W*idx_q +: SLICE_W] : 6'b0;
    alu_cin = drive && ((idx_q == 4'd0) ? (op_q == OP_SUB) : carry_q);
    res_d   = res_q;
    res_d[SLICE_W*idx_q +: SLICE_W] = alu_res;
    ovf_d   = addsub && (a_q[WIDTH-1] == (b_q[WIDTH-1] ^ (op_q == OP_SUB))) &&
              (res_d[WIDTH-1] != a_q[WIDTH-1]);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      res_q        <= '0;
      carry_q      <= 1'b0;
      err_q        <= 1'b0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_carry_q  <= 1'b0;
      out_zero_q   <= 1'b0;
      out_ovf_q    <= 1'b0;
      out_err_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          op_q    <= in_op;
          a_q     <= in_a;
          b_q     <= in_b;
          idx_q   <= '0;
          carry_q <= 1'b0;
          err_q   <= !is_legal_op(in_op);
          state_q <= PASS;
        end
        PASS: if (err_q) begin
          state_q      <= DONE;
          out_valid_q  <= 1'b1;
          out_result_q <= '0;
          out_carry_q  <= 1'b0;
          out_zero_q   <= 1'b1;
          out_ovf_q    <= 1'b0;
          out_err_q    <= 1'b1;
        end else begin
          res_q   <= res_d;
          carry_q <= alu_cout;
          idx_q   <= last ? 4'd0 : idx_q + 4'd1;
          if (last) begin
            state_q      <= DONE;
            out_valid_q  <= 1'b1;
            out_result_q <= res_d;
            out_carry_q  <= addsub && alu_cout;
            out_zero_q   <= res_d == '0;
            out_ovf_q    <= ovf_d;
            out_err_q    <= 1'b0;
          end
        end
        DONE: if (out_ready) begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign in_ready   = state_q == IDLE;
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_carry  = out_carry_q;
  assign out_zero   = out_zero_q;
  assign out_ovf    = out_ovf_q;
  assign out_err    = out_err_q;
endmodule

// File: tb/tb_alu_multipass_seq.sv
// tb_alu_multipass_seq: directed vectors with hand-computed results for the 12-bit sequencer
module tb_alu_multipass_seq;
  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, out_valid, out_ready;
  logic [3:0]  in_op;
  logic [11:0] in_a, in_b, out_result;
  logic        out_carry, out_zero, out_ovf, out_err;
  int          vectors = 0, miscompares = 0;
  alu_multipass_seq dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_carry(out_carry), .out_zero(out_zero), .out_ovf(out_ovf), .out_err(out_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run_op(input string tag, input logic [3:0] op, input logic [11:0] a, b,
                        input logic [11:0] res, input logic c, z, v, e, input int lat);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0; in_op = 4'hF; in_a = 12'hABC; in_b = 12'h123;
    for (int n = 1; n < lat; n++) begin
      chk({tag, "_early_valid"}, 32'(out_valid), 32'd0);
      tick();
    end
    chk({tag, "_early_valid"}, 32'(out_valid), 32'd0);
    tick();
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_result"}, 32'(out_result), 32'(res));
    chk({tag, "_flags"}, 32'({out_carry, out_zero, out_ovf, out_err}), 32'({c, z, v, e}));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    chk({tag, "_ready_back"}, 32'(in_ready), 32'd1);
  endtask
  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_op = 4'h0; in_a = '0; in_b = '0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_outs", 32'({out_valid, out_carry, out_zero, out_ovf, out_err}), 32'd0);
    chk("rst_result", 32'(out_result), 32'd0);
    run_op("add_carrychain", 4'b0010, 12'h03F, 12'h001, 12'h040, 1'b0, 1'b0, 1'b0, 1'b0, 2);
    run_op("sub_borrow",     4'b0110, 12'h100, 12'h001, 12'h0FF, 1'b1, 1'b0, 1'b0, 1'b0, 2);
    run_op("add_ovf",        4'b0010, 12'h7FF, 12'h001, 12'h800, 1'b0, 1'b0, 1'b1, 1'b0, 2);
    run_op("and_zero",       4'b0000, 12'hFFF, 12'h000, 12'h000, 1'b0, 1'b1, 1'b0, 1'b0, 2);
    run_op("nor",            4'b1100, 12'h0F0, 12'h00F, 12'hF00, 1'b0, 1'b0, 1'b0, 1'b0, 2);
    run_op("or",             4'b0001, 12'h0A5, 12'h500, 12'h5A5, 1'b0, 1'b0, 1'b0, 1'b0, 2);
    run_op("sub_neg_ovf",    4'b0110, 12'h800, 12'h001, 12'h7FF, 1'b1, 1'b0, 1'b1, 1'b0, 2);
    run_op("illegal",        4'b0011, 12'h123, 12'h456, 12'h000, 1'b0, 1'b1, 1'b0, 1'b1, 1);
    // backpressure: result held for 5 cycles while a competing request is offered
    in_valid = 1'b1; in_op = 4'b0010; in_a = 12'h123; in_b = 12'h456;
    tick();
    in_op = 4'b0001; in_a = 12'hFFF; in_b = 12'hFFF;
    tick(); tick();
    chk("bp_valid_rise", 32'(out_valid), 32'd1);
    for (int n = 0; n < 5; n++) begin
      tick();
      chk("bp_valid_hold", 32'(out_valid), 32'd1);
      chk("bp_result_hold", 32'(out_result), 32'h579);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    tick();
    chk("bp_no_accept", 32'(in_ready), 32'd1);
    // reset during slice 1 of an ADD discards the operation
    in_valid = 1'b1; in_op = 4'b0010; in_a = 12'h03F; in_b = 12'h001;
    tick();
    in_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_result", 32'(out_result), 32'd0);
    out_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      tick();
      chk("mid_rst_no_emit", 32'(out_valid), 32'd0);
    end
    out_ready = 1'b0;
    run_op("after_rst_add",  4'b0010, 12'hFFF, 12'h001, 12'h000, 1'b1, 1'b1, 1'b0, 1'b0, 2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
